// File: rtl/jpeg_blk_seq_if.sv
// jpeg_blk_seq_if: control/status bundle between the JPEG block sequencer and its surroundings
//   start/start_buf/abort : block requests and cancel (driven by master)
//   busy/done/ovf         : sequencer status
//   in_rd_*               : input BRAM read port control
//   dct_en/mux1/t_wr/t_rd : DCT enable, DCT input mux and transpose strobes
//   mux2_sel/out_*/rec_idx: coefficient-pair select, output BRAM write and reciprocal index
//   blk_cnt               : completed block count
interface jpeg_blk_seq_if #(
  parameter int N = 8,
  parameter int IBUF_W = 1
);
  localparam int W = N / 2;
  localparam int LN = $clog2(N);
  localparam int LW = (W > 1) ? $clog2(W) : 1;
  localparam int AW = 1 + $clog2(N * W);
  localparam int RW = $clog2(N * N);
  logic start;
  logic [IBUF_W-1:0] start_buf;
  logic abort;
  logic busy;
  logic done;
  logic ovf;
  logic in_rd_en;
  logic [IBUF_W+LN-1:0] in_rd_addr;
  logic dct_en;
  logic mux1;
  logic t_wr;
  logic t_rd;
  logic [LW-1:0] mux2_sel;
  logic out_we;
  logic [AW-1:0] out_addr;
  logic [RW-1:0] rec_idx;
  logic out_buf;
  logic [15:0] blk_cnt;
  modport master (
    output start, start_buf, abort,
    input busy, done, ovf, in_rd_en, in_rd_addr, dct_en, mux1, t_wr, t_rd,
    input mux2_sel, out_we, out_addr, rec_idx, out_buf, blk_cnt
  );
  modport slave (
    input start, start_buf, abort,
    output busy, done, ovf, in_rd_en, in_rd_addr, dct_en, mux1, t_wr, t_rd,
    output mux2_sel, out_we, out_addr, rec_idx, out_buf, blk_cnt
  );
endinterface

// File: rtl/jpeg_blk_seq.sv
// jpeg_blk_seq: sequencer for one 2-D DCT + quantisation pass over an NxN block
//   clk_i, rst_i : system clock, synchronous active-high reset
//   bus (slave)  : requests in (start/start_buf/abort); status, BRAM, DCT,
//                  transpose and output-buffer controls out
// A row pass (ROW) reads N input rows and writes the DCT results into the
// transpose; a column pass (COL) reads them back beat by beat and writes W
// coefficient pairs per beat into the ping-pong output buffer.
module jpeg_blk_seq #(
  parameter int N = 8,
  parameter int RD_LAT = 1,
  parameter int DCT_LAT = 4,
  parameter int IBUF_W = 1
) (
  input logic clk_i,
  input logic rst_i,
  jpeg_blk_seq_if.slave bus
);
  localparam int W = N / 2;
  localparam int LN = $clog2(N);
  localparam int LW = (W > 1) ? $clog2(W) : 1;
  localparam int WDW = $clog2(N * W);
  localparam int AW = 1 + WDW;
  localparam int RW = $clog2(N * N);
  localparam int ROWL = N + RD_LAT + DCT_LAT;
  localparam int BEATS = N + DCT_LAT;
  localparam int CW = $clog2(ROWL);
  localparam int BW = $clog2(BEATS);
  localparam logic [CW-1:0] C_LAST = CW'(ROWL - 1);
  localparam logic [CW-1:0] C_RD = CW'(N);
  localparam logic [CW-1:0] C_DS = CW'(RD_LAT);
  localparam logic [CW-1:0] C_DE = CW'(RD_LAT + N + DCT_LAT - 2);
  localparam logic [CW-1:0] C_TS = CW'(RD_LAT + DCT_LAT);
  localparam logic [BW-1:0] B_LAST = BW'(BEATS - 1);
  localparam logic [BW-1:0] B_TR = BW'(N);
  localparam logic [BW-1:0] B_WS = BW'(DCT_LAT);
  localparam logic [LW-1:0] K_LAST = LW'(W - 1);
  typedef enum logic [1:0] {IDLE, ROW, COL} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [BW-1:0] b_q, b_d;
  logic [LW-1:0] k_q, k_d;
  logic [IBUF_W-1:0] ibuf_q, ibuf_d, qbuf_q, qbuf_d;
  logic qfull_q, qfull_d, done_q, done_d, ovf_q, ovf_d, obuf_q, obuf_d;
  logic [15:0] cnt_q, cnt_d;
  logic busy_q, busy_d, rd_q, rd_d, dct_q, dct_d, mux1_q, mux1_d;
  logic twr_q, twr_d, trd_q, trd_d, we_q, we_d;
  logic [IBUF_W+LN-1:0] rda_q, rda_d;
  logic [LW-1:0] sel_q, sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [RW-1:0] rec_q, rec_d;
  logic [WDW-1:0] word_d;
  logic row_end, col_end, busy_eff, req, launch, take;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_q <= '0;
      b_q <= '0;
      k_q <= '0;
      ibuf_q <= '0;
      qbuf_q <= '0;
      qfull_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      obuf_q <= 1'b0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      rd_q <= 1'b0;
      rda_q <= '0;
      dct_q <= 1'b0;
      mux1_q <= 1'b0;
      twr_q <= 1'b0;
      trd_q <= 1'b0;
      we_q <= 1'b0;
      sel_q <= '0;
      addr_q <= '0;
      rec_q <= '0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      b_q <= b_d;
      k_q <= k_d;
      ibuf_q <= ibuf_d;
      qbuf_q <= qbuf_d;
      qfull_q <= qfull_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      obuf_q <= obuf_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      rd_q <= rd_d;
      rda_q <= rda_d;
      dct_q <= dct_d;
      mux1_q <= mux1_d;
      twr_q <= twr_d;
      trd_q <= trd_d;
      we_q <= we_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      rec_q <= rec_d;
    end
  end
  // The done cycle and a pending queued block both count as busy, so a start
  // arriving then is queued (or dropped) instead of launching directly.
  always_comb begin
    row_end = state_q == ROW && c_q == C_LAST;
    col_end = state_q == COL && b_q == B_LAST && k_q == K_LAST;
    busy_eff = state_q != IDLE || done_q || qfull_q;
    req = bus.start && !bus.abort;
    launch = !bus.abort && (qfull_q ? (state_q == IDLE || col_end) : (state_q == IDLE && req && !busy_eff));
    take = busy_eff && req && !qfull_q;
    state_d = bus.abort ? IDLE : launch ? ROW : row_end ? COL : col_end ? IDLE : state_q;
    c_d = (state_q == ROW && state_d == ROW) ? c_q + 1'b1 : '0;
    k_d = (state_q == COL && state_d == COL && k_q != K_LAST) ? k_q + 1'b1 : '0;
    b_d = (state_q == COL && state_d == COL) ? b_q + BW'(k_q == K_LAST) : '0;
    ibuf_d = launch ? (qfull_q ? qbuf_q : bus.start_buf) : ibuf_q;
    qfull_d = !bus.abort && ((qfull_q && !launch) || take);
    qbuf_d = take ? bus.start_buf : qbuf_q;
    ovf_d = busy_eff && req && qfull_q;
    done_d = col_end && !bus.abort;
    cnt_d = cnt_q + 16'(done_d);
    obuf_d = obuf_q ^ done_d;
  end
  // Outputs are decoded from the next state so they register in step with it.
  // Write beats are contiguous, so the word index just follows the last address.
  always_comb begin
    word_d = we_q ? addr_q[WDW-1:0] + 1'b1 : '0;
    busy_d = state_d != IDLE;
    rd_d = state_d == ROW && c_d < C_RD;
    rda_d = rd_d ? {ibuf_d, c_d[LN-1:0]} : '0;
    dct_d = state_d == ROW ? (c_d >= C_DS && c_d <= C_DE) : (state_d == COL && k_d == K_LAST && b_d < B_LAST);
    mux1_d = state_d == COL;
    twr_d = state_d == ROW && c_d >= C_TS;
    trd_d = state_d == COL && k_d == K_LAST && b_d < B_TR;
    we_d = state_d == COL && b_d >= B_WS;
    sel_d = we_d ? k_d : '0;
    addr_d = we_d ? {obuf_q, word_d} : '0;
    rec_d = we_d ? {word_d, 1'b0} : '0;
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf = ovf_q;
  assign bus.in_rd_en = rd_q;
  assign bus.in_rd_addr = rda_q;
  assign bus.dct_en = dct_q;
  assign bus.mux1 = mux1_q;
  assign bus.t_wr = twr_q;
  assign bus.t_rd = trd_q;
  assign bus.mux2_sel = sel_q;
  assign bus.out_we = we_q;
  assign bus.out_addr = addr_q;
  assign bus.rec_idx = rec_q;
  assign bus.out_buf = obuf_q;
  assign bus.blk_cnt = cnt_q;
endmodule

// File: tb/tb_jpeg_blk_seq.sv
// tb_jpeg_blk_seq: scoreboard bench for the default sequencer and an N=4/RD_LAT=2/DCT_LAT=3 variant
module tb_jpeg_blk_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int nd0 = 0;
  int nd1 = 0;
  typedef struct {int addr; int rec; int sel;} wr_t;
  wr_t sb0[$];
  wr_t sb1[$];
  wr_t e0, e1;
  jpeg_blk_seq_if #(.N(8), .IBUF_W(1)) bus0 ();
  jpeg_blk_seq_if #(.N(4), .IBUF_W(1)) bus1 ();
  jpeg_blk_seq #(.N(8), .RD_LAT(1), .DCT_LAT(4), .IBUF_W(1)) u0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  jpeg_blk_seq #(.N(4), .RD_LAT(2), .DCT_LAT(3), .IBUF_W(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [12:0] obs(input int inst);
    return inst == 0 ?
      {bus0.busy, bus0.done, bus0.in_rd_en, 6'(bus0.in_rd_addr), bus0.t_wr, bus0.dct_en, bus0.t_rd, bus0.mux1} :
      {bus1.busy, bus1.done, bus1.in_rd_en, 6'(bus1.in_rd_addr), bus1.t_wr, bus1.dct_en, bus1.t_rd, bus1.mux1};
  endfunction
  // expected strobes at cycle i after ROW c=0 of a lone block
  function automatic logic [12:0] model(input int n, input int rl, input int dl, input int bv, input int i);
    int rowl, coll, w, j, b, k;
    logic busy, done, rd, tw, de, tr, m1;
    logic [5:0] a;
    w = n / 2;
    rowl = n + rl + dl;
    coll = (n + dl) * w;
    busy = i < rowl + coll;
    done = i == rowl + coll;
    {rd, tw, de, tr, m1} = '0;
    a = '0;
    if (i < rowl) begin
      rd = i < n;
      a = rd ? 6'((bv << $clog2(n)) + i) : 6'd0;
      de = i >= rl && i <= rl + n + dl - 2;
      tw = i >= rl + dl;
    end else if (i < rowl + coll) begin
      j = i - rowl;
      b = j / w;
      k = j % w;
      de = k == w - 1 && b < n + dl - 1;
      tr = k == w - 1 && b < n;
      m1 = 1'b1;
    end
    return {busy, done, rd, a, tw, de, tr, m1};
  endfunction
  task automatic push_blk(input int inst, input int n, input int ob);
    wr_t e;
    int w = n / 2;
    for (int wd = 0; wd < n * w; wd++) begin
      e.addr = ob * n * w + wd;
      e.rec = 2 * wd;
      e.sel = wd % w;
      if (inst == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
  endtask
  task automatic pulse(input int inst, input logic b);
    if (inst == 0) begin
      bus0.start = 1'b1;
      bus0.start_buf = b;
    end else begin
      bus1.start = 1'b1;
      bus1.start_buf = b;
    end
    step();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask
  task automatic wait_done(input int inst, input int budget, output int c);
    c = -1;
    for (int t = 0; t < budget && c < 0; t++) begin
      if (inst == 0 ? bus0.done : bus1.done) c = cyc;
      else step();
    end
    if (c < 0) chk("done_timeout", 0, 1);
  endtask
  always @(negedge clk) begin
    if (bus0.done) nd0++;
    if (bus1.done) nd1++;
    if (!rst && bus0.out_we) begin
      if (sb0.size() == 0) chk("wr0_extra", 1, 0);
      else begin
        e0 = sb0.pop_front();
        chk("wr0_addr", bus0.out_addr, e0.addr);
        chk("wr0_rec", bus0.rec_idx, e0.rec);
        chk("wr0_sel", bus0.mux2_sel, e0.sel);
      end
    end
    if (!rst && bus1.out_we) begin
      if (sb1.size() == 0) chk("wr1_extra", 1, 0);
      else begin
        e1 = sb1.pop_front();
        chk("wr1_addr", bus1.out_addr, e1.addr);
        chk("wr1_rec", bus1.rec_idx, e1.rec);
        chk("wr1_sel", bus1.mux2_sel, e1.sel);
      end
    end
  end
  initial begin
    int ca, cb, base;
    {bus0.start, bus0.start_buf, bus0.abort} = '0;
    {bus1.start, bus1.start_buf, bus1.abort} = '0;
    repeat (3) step();
    chk("rst_obs0", obs(0), 0);
    chk("rst_obs1", obs(1), 0);
    chk("rst_cnt0", bus0.blk_cnt, 0);
    chk("rst_obuf0", bus0.out_buf, 0);
    rst = 1'b0;
    step();
    // single block, buffer 1
    push_blk(0, 8, 0);
    pulse(0, 1'b1);
    for (int i = 0; i < 63; i++) begin
      chk("single_cyc", obs(0), model(8, 1, 4, 1, i));
      if (i == 61) begin
        chk("single_cnt", bus0.blk_cnt, 1);
        chk("single_obuf", bus0.out_buf, 1);
      end
      step();
    end
    chk("single_sb", sb0.size(), 0);
    // back-to-back: second request queued during COL
    push_blk(0, 8, 1);
    pulse(0, 1'b0);
    repeat (20) step();
    push_blk(0, 8, 0);
    pulse(0, 1'b1);
    wait_done(0, 100, ca);
    chk("b2b_busy", bus0.busy, 1);
    chk("b2b_rd", bus0.in_rd_en, 1);
    chk("b2b_rdaddr", bus0.in_rd_addr, 8);
    step();
    wait_done(0, 100, cb);
    chk("b2b_gap", cb - ca, 61);
    chk("b2b_cnt", bus0.blk_cnt, 3);
    chk("b2b_obuf", bus0.out_buf, 1);
    step();
    // three requests: one runs, one queues, one overflows
    base = nd0;
    push_blk(0, 8, 1);
    pulse(0, 1'b0);
    repeat (4) step();
    push_blk(0, 8, 0);
    pulse(0, 1'b1);
    chk("q_noovf", bus0.ovf, 0);
    repeat (4) step();
    pulse(0, 1'b0);
    chk("ovf_hi", bus0.ovf, 1);
    step();
    chk("ovf_lo", bus0.ovf, 0);
    wait_done(0, 100, ca);
    step();
    wait_done(0, 100, cb);
    repeat (70) step();
    chk("q_dones", nd0 - base, 2);
    chk("q_cnt", bus0.blk_cnt, 5);
    chk("q_obuf", bus0.out_buf, 1);
    // abort during COL beat 6
    base = nd0;
    push_blk(0, 8, 1);
    pulse(0, 1'b0);
    repeat (37) step();
    chk("ab_we_pre", bus0.out_we, 1);
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    sb0.delete();
    chk("ab_we", bus0.out_we, 0);
    chk("ab_busy", bus0.busy, 0);
    chk("ab_obs", obs(0), 0);
    repeat (3) step();
    chk("ab_nodone", nd0 - base, 0);
    chk("ab_cnt", bus0.blk_cnt, 5);
    chk("ab_obuf", bus0.out_buf, 1);
    // abort beats a simultaneous start
    bus0.abort = 1'b1;
    pulse(0, 1'b0);
    bus0.abort = 1'b0;
    chk("abst_busy", bus0.busy, 0);
    step();
    chk("abst_busy2", bus0.busy, 0);
    push_blk(0, 8, 1);
    pulse(0, 1'b1);
    wait_done(0, 100, ca);
    chk("ab_new_cnt", bus0.blk_cnt, 6);
    chk("ab_new_obuf", bus0.out_buf, 0);
    chk("ab_new_sb", sb0.size(), 0);
    step();
    // reset mid-ROW with a queued request
    base = nd0;
    pulse(0, 1'b1);
    repeat (2) step();
    pulse(0, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_obs", obs(0), 0);
    chk("mrst_we", bus0.out_we, 0);
    chk("mrst_cnt", bus0.blk_cnt, 0);
    chk("mrst_obuf", bus0.out_buf, 0);
    repeat (80) step();
    chk("mrst_nodone", nd0 - base, 0);
    chk("mrst_busy", bus0.busy, 0);
    // small variant: N=4, RD_LAT=2, DCT_LAT=3
    push_blk(1, 4, 0);
    pulse(1, 1'b1);
    for (int i = 0; i < 25; i++) begin
      chk("n4_cyc", obs(1), model(4, 2, 3, 1, i));
      if (i == 23) chk("n4_cnt", bus1.blk_cnt, 1);
      step();
    end
    chk("n4_sb", sb1.size(), 0);
    chk("n4_obuf", bus1.out_buf, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
